// File: rtl/branch_ctrl_pkg.sv
// rtl/branch_ctrl_pkg.sv - shared pipeline branch definitions
package branch_ctrl_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BLEZ = 4'd3,
        BR_BGTZ = 4'd4,
        BR_BLTZ = 4'd5,
        BR_BGEZ = 4'd6,
        BR_J    = 4'd7,
        BR_JAL  = 4'd8,
        BR_JR   = 4'd9,
        BR_JALR = 4'd10
    } br_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DSLOT = 2'd2
    } br_state_e;

    function automatic logic op_is_br(input logic [3:0] op);
        return (op >= BR_BEQ) && (op <= BR_JALR);
    endfunction

    // J/JAL are the only branches that never depend on forwarded operands
    function automatic logic op_needs_opnd(input logic [3:0] op);
        return ((op >= BR_BEQ) && (op <= BR_BGEZ)) || (op == BR_JR) || (op == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_ctrl_target.sv
// rtl/branch_ctrl_target.sv - branch target and link address arithmetic
module br_target (
    input  logic [31:0] d_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_val,
    output logic [31:0] cond_tgt,
    output logic [31:0] jump_tgt,
    output logic [31:0] reg_tgt,
    output logic [31:0] link_val
);

    logic [31:0] pc4;

    assign pc4      = d_pc + 32'd4;
    assign cond_tgt = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign jump_tgt = {pc4[31:28], instr_index, 2'b00};
    assign reg_tgt  = rs_val;
    assign link_val = d_pc + 32'd8;

endmodule

// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - decode-stage branch resolution, delay-slot tracking and counters
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic             d_advance,
    input  logic [3:0]       br_op,
    input  logic             opnd_ready,
    input  logic             eq,
    input  logic             eqz,
    input  logic             ltz,
    input  logic [31:0]      d_pc,
    input  logic [15:0]      imm16,
    input  logic [25:0]      instr_index,
    input  logic [31:0]      rs_val,
    output logic             stall,
    output logic             redirect,
    output logic [31:0]      target,
    output logic [31:0]      link_val,
    output logic             in_dslot,
    output logic             ds_err,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    br_state_e   state, state_nxt;
    logic        is_br, needs_opnd, resolved, taken, resolve_evt;
    logic [31:0] cond_tgt, jump_tgt, reg_tgt, sel_tgt;

    br_target u_tgt (
        .d_pc        (d_pc),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_val      (rs_val),
        .cond_tgt    (cond_tgt),
        .jump_tgt    (jump_tgt),
        .reg_tgt     (reg_tgt),
        .link_val    (link_val)
    );

    assign is_br       = d_valid & op_is_br(br_op);
    assign needs_opnd  = op_needs_opnd(br_op);
    assign resolved    = !needs_opnd | opnd_ready;
    assign in_dslot    = (state == ST_DSLOT);
    assign stall       = is_br & needs_opnd & !opnd_ready & !in_dslot;
    assign redirect    = is_br & resolved & taken & !in_dslot;
    assign target      = redirect ? sel_tgt : 32'd0;
    assign resolve_evt = is_br & resolved & d_advance & !in_dslot;

    always_comb begin
        taken   = 1'b0;
        sel_tgt = cond_tgt;
        case (br_op)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLEZ: taken = ltz | eqz;
            BR_BGTZ: taken = !ltz & !eqz;
            BR_BLTZ: taken = ltz;
            BR_BGEZ: taken = !ltz;
            BR_J, BR_JAL: begin
                taken   = 1'b1;
                sel_tgt = jump_tgt;
            end
            BR_JR, BR_JALR: begin
                taken   = 1'b1;
                sel_tgt = reg_tgt;
            end
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (stall)
                    state_nxt = ST_WAIT;
                else if (is_br & resolved & d_advance)
                    state_nxt = ST_DSLOT;
            end
            ST_WAIT: begin
                // a flush of D abandons the pending branch
                if (!d_valid)
                    state_nxt = ST_IDLE;
                else if (opnd_ready & d_advance)
                    state_nxt = ST_DSLOT;
            end
            ST_DSLOT: begin
                if (d_valid & d_advance)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            ds_err    <= 1'b0;
            br_cnt    <= '0;
            taken_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (in_dslot & is_br & d_advance)
                ds_err <= 1'b1;
            if (resolve_evt) begin
                br_cnt    <= br_cnt + CNT_W'(1);
                taken_cnt <= taken_cnt + CNT_W'(taken);
            end
        end
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Decode-stage branch resolution controller for the five-stage MIPS pipeline. It consumes the comparator flags (eq, eqz, ltz) together with the decoded branch op and produces the redirect request and target for the NPC logic, the link value for JAL/JALR, and the D-stage stall request while forwarded operands are pending. It also tracks the architectural delay slot, flags illegal branch-in-delay-slot, and keeps branch/taken performance counters.

## Interface
Parameters:
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- d_valid  in  1  D stage holds a valid instruction
- d_advance  in  1  D/E register captures the D instruction at this edge
- br_op  in  4  branch op: NONE=0, BEQ=1, BNE=2, BLEZ=3, BGTZ=4, BLTZ=5, BGEZ=6, J=7, JAL=8, JR=9, JALR=10; 11–15 treated as NONE
- opnd_ready  in  1  forwarded rs/rt operands are final this cycle
- eq, eqz, ltz  in  1 each  comparator flags for the current operands
- d_pc  in  32  PC of the D instruction
- imm16  in  16  branch offset field
- instr_index  in  26  J/JAL index field
- rs_val  in  32  forwarded rs, JR/JALR target
- stall  out  1  hold F and D this cycle
- redirect  out  1  NPC must load target at the next fetch after the delay slot
- target  out  32  redirect address
- link_val  out  32  d_pc + 8
- in_dslot  out  1  current D instruction is a delay slot
- ds_err  out  1  sticky: branch seen in a delay slot
- br_cnt, taken_cnt  out  CNT_W each  resolved / taken branch counts

## Operation
- is_br = d_valid & (br_op in 1..10). Conditional ops resolve only when opnd_ready; J/JAL never wait, so they are always resolved in their first D cycle.
- Conditions: BEQ eq; BNE !eq; BLEZ ltz|eqz; BGTZ !ltz&!eqz; BLTZ ltz; BGEZ !ltz; J/JAL/JR/JALR always taken.
- Targets, all mod 2^32: conditional = d_pc + 4 + (sext(imm16) << 2); J/JAL = {(d_pc+4)[31:28], instr_index, 2'b00}; JR/JALR = rs_val with no alignment check.
- stall = is_br & needs_opnd & !opnd_ready & !in_dslot. JR/JALR and the conditional ops need operands.
- redirect = is_br & resolved & taken & !in_dslot; combinational; target is valid whenever redirect=1; otherwise target = 0.
- FSM states:
  - IDLE:
    - is_br & stall -> WAIT
    - is_br & resolved & d_advance -> DSLOT
  - WAIT:
    - opnd_ready & d_advance -> DSLOT
    - !d_valid (flush) -> IDLE
    - otherwise hold
  - DSLOT:
    - d_valid & d_advance -> IDLE
    - if that instruction is_br, set ds_err; its redirect and stall are suppressed and it is not counted.
- in_dslot = (state == DSLOT).
- Counters increment on the resolve edge (is_br & resolved & d_advance & !in_dslot):
  - br_cnt += 1
  - taken_cnt += taken
  - wrap to 0 at 2^CNT_W.

## Timing
- Reset, on the first clk edge with reset=0:
  - state IDLE
  - ds_err 0
  - br_cnt 0
  - taken_cnt 0
  - in_dslot 0
- stall, redirect, target and link_val are combinational from inputs and state: zero-cycle latency, same cycle as the flags.
- Reset mid-operation (WAIT or DSLOT) returns to IDLE with no redirect pending at the next edge.
- A branch in WAIT whose operands become ready while d_advance=0 (external stall) keeps redirect asserted each cycle until the advancing edge. It is counted exactly once.
- ds_err is cleared only by reset.

## Structure
- The br_op encodings and the BR_NONE…BR_JALR constants go in the shared pipeline definitions header, used by the controller and this block.
- One combinational sub-module, br_target: it computes the three target forms and link_val. The FSM, condition mux and counters stay in branch_ctrl.

## Test plan
- BEQ with eq=1, opnd_ready=1, d_pc=0x3000, imm16=0x0004, d_advance=1 -> redirect=1, target=0x3014, stall=0; next cycle in_dslot=1; br_cnt=1, taken_cnt=1.
- BGTZ with ltz=0, eqz=0, but opnd_ready=0 for 2 cycles then 1 -> stall=1 for 2 cycles, WAIT, then redirect=1 in the third cycle; br_cnt increments once.
- JAL with d_pc=0x0000_3008, instr_index=0x0000C10 -> target=0x0000_3040, link_val=0x0000_3010, no stall even with opnd_ready=0.
- BNE in delay slot after taken J -> redirect=0, ds_err=1 and stays 1; counters unchanged by the slot instruction.
- BEQ with imm16=0xFFFF at d_pc=0x0000_0000 -> target=0x0000_0000; JR with rs_val=0xFFFF_FFFE -> target=0xFFFF_FFFE.
- Assert reset while in WAIT with br_cnt=0xFFFF_FFFF -> next edge state IDLE, counters 0; separately, 2^32 resolves wrap br_cnt to 0.
